// File: rtl/warp_kernel_fetch_pkg.sv
// Shared types and defaults for the warp kernel fetch unit.
package warp_pkg;

  localparam int NUM_LANES_DEFAULT   = 4;
  localparam int ADDR_WIDTH          = 32;
  localparam int FETCH_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // One prefetched instruction: the word and the byte address it came from.
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } instr_entry_t;

endpackage

// File: rtl/warp_kernel_fetch_fifo.sv
// Registered synchronous FIFO with occupancy count; output is the head entry.
module warp_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  // A pop on empty is ignored; a push on full is accepted only alongside a pop.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  assign pop_data_o = mem_q[rd_ptr_q];
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;

  // Storage, pointers and occupancy; storage is cleared so outputs read 0 after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/warp_kernel_fetch.sv
// Kernel instruction fetcher: streams a kernel from memory through a small
// prefetch FIFO and issues it in order to the warp lanes with the lane mask.
module warp_kernel_fetch
  import warp_pkg::*;
#(
  parameter int NUM_LANES   = warp_pkg::NUM_LANES_DEFAULT,
  parameter int ADDR_WIDTH  = warp_pkg::ADDR_WIDTH,
  parameter int FETCH_DEPTH = warp_pkg::FETCH_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  kernel_start,
  input  logic [31:0]           kernel_addr,
  input  logic [15:0]           kernel_length,
  output logic                  kernel_done,
  output logic                  kernel_error,
  input  logic                  mask_update,
  input  logic [NUM_LANES-1:0]  mask_value,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_write,
  input  logic                  mem_resp_valid,
  output logic                  mem_resp_ready,
  input  logic [31:0]           mem_resp_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instr_data,
  output logic [31:0]           instr_pc,
  output logic [NUM_LANES-1:0]  instr_mask,
  output logic                  busy
);

  localparam int CW = $clog2(FETCH_DEPTH) + 1;

  fetch_state_e         state_q;
  logic [31:0]          base_q;
  logic [15:0]          len_q, req_cnt_q, resp_cnt_q, issue_cnt_q;
  logic [CW-1:0]        inflight_q;
  logic [NUM_LANES-1:0] mask_q;
  logic                 done_q, err_q;

  logic [CW-1:0]        fifo_count;
  logic                 fifo_empty;
  instr_entry_t         push_entry, head_entry;
  logic                 req_hs, resp_acc, issue_hs;
  logic [CW:0]          credit_used;
  logic [31:0]          req_byte;

  // Credits cover both words in flight and words already buffered, so the
  // FIFO can never be asked to hold more than it has room for.
  assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign req_byte    = base_q + {14'b0, req_cnt_q, 2'b00};

  assign mem_req_valid  = (state_q == ST_FETCH) && (req_cnt_q < len_q) &&
                          (credit_used < (CW+1)'(FETCH_DEPTH));
  assign mem_req_addr   = req_byte[ADDR_WIDTH-1:0];
  assign mem_req_write  = 1'b0;
  assign mem_resp_ready = 1'b1;

  assign req_hs   = mem_req_valid && mem_req_ready;
  // Responses with nothing outstanding are stale (e.g. from before a reset).
  assign resp_acc = mem_resp_valid && (inflight_q != '0);
  assign issue_hs = instr_valid && instr_ready;

  assign push_entry.data = mem_resp_data;
  assign push_entry.pc   = base_q + {14'b0, resp_cnt_q, 2'b00};

  warp_sync_fifo #(
    .WIDTH ($bits(instr_entry_t)),
    .DEPTH (FETCH_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (resp_acc),
    .push_data_i (push_entry),
    .pop_i       (issue_hs),
    .pop_data_o  (head_entry),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign instr_valid  = !fifo_empty;
  assign instr_data   = head_entry.data;
  assign instr_pc     = head_entry.pc;
  assign instr_mask   = mask_q;
  assign kernel_done  = done_q;
  assign kernel_error = err_q;
  assign busy         = (state_q != ST_IDLE);

  // Launch/fetch/drain FSM with its counters and registered done/error pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      req_cnt_q   <= '0;
      resp_cnt_q  <= '0;
      issue_cnt_q <= '0;
      inflight_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (req_hs)   req_cnt_q   <= req_cnt_q + 16'd1;
      if (resp_acc) resp_cnt_q  <= resp_cnt_q + 16'd1;
      if (issue_hs) issue_cnt_q <= issue_cnt_q + 16'd1;
      inflight_q <= inflight_q + CW'(req_hs) - CW'(resp_acc);
      case (state_q)
        ST_IDLE: begin
          if (kernel_start) begin
            if (kernel_addr[1:0] != 2'b00) begin
              err_q <= 1'b1;
            end else if (kernel_length == 16'd0) begin
              done_q <= 1'b1;
            end else begin
              base_q      <= kernel_addr;
              len_q       <= kernel_length;
              req_cnt_q   <= '0;
              resp_cnt_q  <= '0;
              issue_cnt_q <= '0;
              inflight_q  <= '0;
              state_q     <= ST_FETCH;
            end
          end
        end
        // Leave on the handshake of the last request; the last issue always
        // follows its response, so completion is only ever seen in DRAIN.
        ST_FETCH: begin
          if (req_hs && (req_cnt_q + 16'd1 == len_q)) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (issue_hs && (issue_cnt_q + 16'd1 == len_q)) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Live lane mask; updates land the cycle after mask_update in any state.
  always_ff @(posedge clk) begin
    if (!rst_n)           mask_q <= '1;
    else if (mask_update) mask_q <= mask_value;
  end

endmodule
